// File: rtl/kbd_text_writer.sv
// PS/2 scan-code to text-buffer writer: pops one code per visit to IDLE, decodes
// make/break/extended prefixes with Shift, and drives a row-major character memory.
module kbd_text_writer #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    kb_data,
    input  logic          kb_ready,
    input  logic          kb_overflow,
    output logic          kb_nextdata_n,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [4:0]    cursor_row,
    output logic [6:0]    cursor_col,
    output logic [7:0]    last_ascii,
    output logic [7:0]    key_count,
    output logic          ovf_err
);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_PROC, S_WR} state_t;

    state_t        state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic          shift_q, shift_d, brk_q, brk_d, ext_q, ext_d;
    logic [4:0]    row_q, row_d;
    logic [6:0]    col_q, col_d;
    logic [7:0]    last_q, last_d, count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;

    // Decode results; inputs are stable across PROC and WR, so both states share them.
    logic          dec_write, dec_print, dec_shift, dec_brk, dec_ext;
    logic [7:0]    dec_data;
    logic [4:0]    dec_row, wpos_row, row_inc;
    logic [6:0]    dec_col, wpos_col;
    logic [8:0]    lk;
    logic          is_shift_code;

    function automatic logic [8:0] ascii_lookup(input logic [7:0] code, input logic shift);
        logic [7:0] base;
        base = shift ? 8'h41 : 8'h61;
        ascii_lookup = 9'h000;
        case (code)
            8'h1C: ascii_lookup = {1'b1, base + 8'd0};
            8'h32: ascii_lookup = {1'b1, base + 8'd1};
            8'h21: ascii_lookup = {1'b1, base + 8'd2};
            8'h23: ascii_lookup = {1'b1, base + 8'd3};
            8'h24: ascii_lookup = {1'b1, base + 8'd4};
            8'h2B: ascii_lookup = {1'b1, base + 8'd5};
            8'h34: ascii_lookup = {1'b1, base + 8'd6};
            8'h33: ascii_lookup = {1'b1, base + 8'd7};
            8'h43: ascii_lookup = {1'b1, base + 8'd8};
            8'h3B: ascii_lookup = {1'b1, base + 8'd9};
            8'h42: ascii_lookup = {1'b1, base + 8'd10};
            8'h4B: ascii_lookup = {1'b1, base + 8'd11};
            8'h3A: ascii_lookup = {1'b1, base + 8'd12};
            8'h31: ascii_lookup = {1'b1, base + 8'd13};
            8'h44: ascii_lookup = {1'b1, base + 8'd14};
            8'h4D: ascii_lookup = {1'b1, base + 8'd15};
            8'h15: ascii_lookup = {1'b1, base + 8'd16};
            8'h2D: ascii_lookup = {1'b1, base + 8'd17};
            8'h1B: ascii_lookup = {1'b1, base + 8'd18};
            8'h2C: ascii_lookup = {1'b1, base + 8'd19};
            8'h3C: ascii_lookup = {1'b1, base + 8'd20};
            8'h2A: ascii_lookup = {1'b1, base + 8'd21};
            8'h1D: ascii_lookup = {1'b1, base + 8'd22};
            8'h22: ascii_lookup = {1'b1, base + 8'd23};
            8'h35: ascii_lookup = {1'b1, base + 8'd24};
            8'h1A: ascii_lookup = {1'b1, base + 8'd25};
            8'h45: ascii_lookup = 9'h130;
            8'h16: ascii_lookup = 9'h131;
            8'h1E: ascii_lookup = 9'h132;
            8'h26: ascii_lookup = 9'h133;
            8'h25: ascii_lookup = 9'h134;
            8'h2E: ascii_lookup = 9'h135;
            8'h36: ascii_lookup = 9'h136;
            8'h3D: ascii_lookup = 9'h137;
            8'h3E: ascii_lookup = 9'h138;
            8'h46: ascii_lookup = 9'h139;
            8'h29: ascii_lookup = 9'h120;
            8'h4E: ascii_lookup = 9'h12D;
            8'h55: ascii_lookup = 9'h13D;
            default: ascii_lookup = 9'h000;
        endcase
    endfunction

    always_comb begin
        dec_row       = row_q;
        dec_col       = col_q;
        dec_shift     = shift_q;
        dec_brk       = brk_q;
        dec_ext       = ext_q;
        dec_write     = 1'b0;
        dec_print     = 1'b0;
        dec_data      = 8'h20;
        wpos_row      = row_q;
        wpos_col      = col_q;
        lk            = ascii_lookup(code_q, shift_q);
        is_shift_code = (code_q == 8'h12) || (code_q == 8'h59);
        row_inc       = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

        if (code_q == 8'hF0) begin
            dec_brk = 1'b1;
        end else if (code_q == 8'hE0) begin
            dec_ext = 1'b1;
        end else if (ext_q) begin
            dec_ext = 1'b0;
            dec_brk = 1'b0;
        end else if (brk_q) begin
            if (is_shift_code) dec_shift = 1'b0;
            dec_brk = 1'b0;
        end else if (is_shift_code) begin
            dec_shift = 1'b1;
        end else if (code_q == 8'h5A) begin
            dec_col = 7'd0;
            dec_row = row_inc;
        end else if (code_q == 8'h66) begin
            // Backspace blanks the cell it steps back onto.
            dec_write = 1'b1;
            if (col_q != 7'd0) begin
                dec_col = col_q - 7'd1;
            end else if (row_q != 5'd0) begin
                dec_row = row_q - 5'd1;
                dec_col = 7'(COLS - 1);
            end
            wpos_row = dec_row;
            wpos_col = dec_col;
        end else if (lk[8]) begin
            dec_write = 1'b1;
            dec_print = 1'b1;
            dec_data  = lk[7:0];
            if (col_q != 7'(COLS - 1)) begin
                dec_col = col_q + 7'd1;
            end else begin
                dec_col = 7'd0;
                dec_row = row_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            code_q    <= 8'h00;
            shift_q   <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            row_q     <= 5'd0;
            col_q     <= 7'd0;
            last_q    <= 8'h00;
            count_q   <= 8'h00;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            shift_q   <= shift_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            row_q     <= row_d;
            col_q     <= col_d;
            last_q    <= last_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (kb_ready) state_d = S_POP;
            S_POP:   state_d = S_PROC;
            S_PROC:  state_d = S_WR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        code_d    = code_q;
        shift_d   = shift_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        row_d     = row_q;
        col_d     = col_q;
        last_d    = last_q;
        count_d   = count_q;
        ovf_d     = ovf_q | kb_overflow;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: if (kb_ready) code_d = kb_data;
            S_PROC: begin
                wr_en_d = dec_write;
                if (dec_write) begin
                    wr_addr_d = AW'(wpos_row) * AW'(COLS) + AW'(wpos_col);
                    wr_data_d = dec_data;
                end
            end
            S_WR: begin
                shift_d = dec_shift;
                brk_d   = dec_brk;
                ext_d   = dec_ext;
                row_d   = dec_row;
                col_d   = dec_col;
                if (dec_print) begin
                    last_d  = dec_data;
                    count_d = count_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Strobes are masked by reset so an in-flight code is neither popped nor written.
    assign kb_nextdata_n = ~((state_q == S_POP) && resetn);
    assign wr_en         = wr_en_q & resetn;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign cursor_row    = row_q;
    assign cursor_col    = col_q;
    assign last_ascii    = last_q;
    assign key_count     = count_q;
    assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_kbd_text_writer.sv
// Self-checking bench for kbd_text_writer: randomized scan-code streams compared
// against a linear-position text-editor model.
module tb_kbd_text_writer;

    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int AW   = 12;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    kb_data = 8'h00;
    logic          kb_ready = 1'b0;
    logic          kb_overflow = 1'b0;
    logic          kb_nextdata_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [4:0]    cursor_row;
    logic [6:0]    cursor_col;
    logic [7:0]    last_ascii;
    logic [7:0]    key_count;
    logic          ovf_err;

    int n_pass  = 0;
    int n_total = 0;

    kbd_text_writer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .cursor_row(cursor_row),
        .cursor_col(cursor_col), .last_ascii(last_ascii), .key_count(key_count),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};

    // Reference model: cursor kept as a single linear position on the screen.
    int m_pos, m_last, m_count;
    bit m_shift, m_brk, m_ext;

    function automatic int ascii_of(input logic [7:0] c, input bit sh);
        for (int i = 0; i < 26; i++) if (letter_codes[i] == c) return (sh ? 65 : 97) + i;
        for (int i = 0; i < 10; i++) if (digit_codes[i] == c) return 48 + i;
        if (c == 8'h29) return 32;
        if (c == 8'h4E) return 45;
        if (c == 8'h55) return 61;
        return -1;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_last = 0; m_count = 0;
        m_shift = 0; m_brk = 0; m_ext = 0;
    endtask

    task automatic model_apply(input logic [7:0] code, output bit ew, output int ea, output int ed);
        int a;
        ew = 0; ea = 0; ed = 0;
        a = ascii_of(code, m_shift);
        if (code == 8'hF0) m_brk = 1;
        else if (code == 8'hE0) m_ext = 1;
        else if (m_ext) begin m_ext = 0; m_brk = 0; end
        else if (m_brk) begin
            if (code == 8'h12 || code == 8'h59) m_shift = 0;
            m_brk = 0;
        end
        else if (code == 8'h12 || code == 8'h59) m_shift = 1;
        else if (code == 8'h5A) m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
        else if (code == 8'h66) begin
            if (m_pos > 0) m_pos--;
            ew = 1; ea = m_pos; ed = 32;
        end
        else if (a >= 0) begin
            ew = 1; ea = m_pos; ed = a;
            m_pos = (m_pos + 1) % (COLS * ROWS);
            m_last = a;
            m_count = (m_count + 1) % 256;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; kb_ready = 1'b0; kb_overflow = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // Drives one code starting at a negedge; ends on the negedge where the new cursor shows.
    task automatic drive(input logic [7:0] code, input bit hold,
                         output logic [33:0] got, output logic [33:0] exp);
        bit ok; logic w; logic [11:0] a; logic [7:0] d; bit ew; int ea, ed;
        ok = 1;
        kb_data = code; kb_ready = 1'b1;
        @(posedge clk); #1;
        if (!hold) kb_ready = 1'b0;
        @(negedge clk);
        if (kb_nextdata_n !== 1'b0 || wr_en !== 1'b0) ok = 0;
        if (hold) kb_data = 8'($urandom);
        @(negedge clk);
        if (kb_nextdata_n !== 1'b1 || wr_en !== 1'b0) ok = 0;
        @(negedge clk);
        w = wr_en; a = wr_addr; d = wr_data;
        if (kb_nextdata_n !== 1'b1) ok = 0;
        @(negedge clk);
        if (wr_en !== 1'b0) ok = 0;
        model_apply(code, ew, ea, ed);
        got = {ok, w, (w === 1'b1) ? a : 12'h0, (w === 1'b1) ? d : 8'h0, cursor_row, cursor_col};
        exp = {1'b1, ew, ew ? 12'(ea) : 12'h0, ew ? 8'(ed) : 8'h0, 5'(m_pos / COLS), 7'(m_pos % COLS)};
        $display("txn code=%02h wr=%0b addr=%0d data=%02h cursor=(%0d,%0d)",
                 code, w, a, d, cursor_row, cursor_col);
    endtask

    function automatic logic [7:0] rand_printable();
        logic [7:0] c;
        case ($urandom_range(0, 2))
            0: c = digit_codes[$urandom_range(0, 9)];
            1: c = 8'h29;
            default: c = letter_codes[$urandom_range(0, 25)];
        endcase
        return c;
    endfunction

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({kb_nextdata_n, wr_en, wr_addr, wr_data, cursor_row, cursor_col, last_ascii, key_count, ovf_err}
                !== {1'b1, 50'd0})
            $display("FAIL reset_state got=%h exp=%h",
                {kb_nextdata_n, wr_en, wr_addr, wr_data, cursor_row, cursor_col, last_ascii, key_count, ovf_err},
                {1'b1, 50'd0});
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [33:0] got, exp;
        do_reset();
        drive(8'h1C, 0, got, exp);
        n_total++;
        if (got !== exp || exp !== {2'b11, 12'd0, 8'h61, 5'd0, 7'd1})
            $display("FAIL basic_a got=%h exp=%h", got, exp);
        else n_pass++;
        n_total++;
        if ({last_ascii, key_count} !== {8'(m_last), 8'(m_count)})
            $display("FAIL basic_counters got=%h exp=%h", {last_ascii, key_count}, {8'(m_last), 8'(m_count)});
        else n_pass++;
    endtask

    task automatic test_shift();
        logic [7:0] seq [7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
        logic [33:0] got, exp;
        int writes = 0;
        do_reset();
        foreach (seq[i]) begin
            drive(seq[i], 0, got, exp);
            if (got[32] === 1'b1) writes++;
            n_total++;
            if (got !== exp) $display("FAIL shift_seq code=%02h got=%h exp=%h", seq[i], got, exp);
            else n_pass++;
        end
        n_total++;
        if (writes != 2) $display("FAIL shift_write_count got=%0d exp=2", writes);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [33:0] got, exp;
        logic [7:0] c;
        do_reset();
        for (int i = 0; i < COLS - 1; i++) begin
            c = rand_printable();
            drive(c, 0, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL wrap_fill code=%02h got=%h exp=%h", c, got, exp);
            else n_pass++;
        end
        drive(8'h16, 0, got, exp);
        n_total++;
        if (got !== exp || exp !== {2'b11, 12'd69, 8'h31, 5'd1, 7'd0})
            $display("FAIL wrap_row_end got=%h exp=%h", got, exp);
        else n_pass++;
        for (int i = 0; i < ROWS - 2; i++) drive(8'h5A, 0, got, exp);
        for (int i = 0; i < COLS - 1; i++) drive(rand_printable(), 0, got, exp);
        drive(8'h45, 0, got, exp);
        n_total++;
        if (got !== exp || exp !== {2'b11, 12'd2099, 8'h30, 5'd0, 7'd0})
            $display("FAIL wrap_screen_end got=%h exp=%h", got, exp);
        else n_pass++;
    endtask

    task automatic test_backspace();
        logic [33:0] got, exp;
        do_reset();
        for (int i = 0; i < COLS; i++) drive(rand_printable(), 0, got, exp);
        drive(8'h66, 0, got, exp);
        n_total++;
        if (got !== exp || exp !== {2'b11, 12'd69, 8'h20, 5'd0, 7'd69})
            $display("FAIL bksp_row_back got=%h exp=%h", got, exp);
        else n_pass++;
        do_reset();
        drive(8'h66, 0, got, exp);
        n_total++;
        if (got !== exp || exp !== {2'b11, 12'd0, 8'h20, 5'd0, 7'd0})
            $display("FAIL bksp_origin got=%h exp=%h", got, exp);
        else n_pass++;
    endtask

    task automatic test_ext_enter();
        logic [7:0] seq [6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h5A};
        logic [33:0] got, exp;
        do_reset();
        for (int i = 0; i < 3; i++) drive(8'h5A, 0, got, exp);
        for (int i = 0; i < 12; i++) drive(rand_printable(), 0, got, exp);
        foreach (seq[i]) begin
            drive(seq[i], 0, got, exp);
            n_total++;
            if (got !== exp || got[32] !== 1'b0)
                $display("FAIL ext_enter code=%02h got=%h exp=%h", seq[i], got, exp);
            else n_pass++;
        end
        n_total++;
        if ({cursor_row, cursor_col} !== {5'd4, 7'd0})
            $display("FAIL enter_cursor got=(%0d,%0d) exp=(4,0)", cursor_row, cursor_col);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [33:0] got, exp;
        logic [7:0] c;
        for (int i = 0; i < 10; i++) begin
            c = (i == 3) ? 8'h59 : rand_printable();
            drive(c, i != 9, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL back_to_back code=%02h got=%h exp=%h", c, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        n_total++;
        if (ovf_err !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf_err);
        else n_pass++;
        kb_overflow = 1'b1;
        @(negedge clk);
        kb_overflow = 1'b0;
        repeat (5) @(negedge clk);
        n_total++;
        if (ovf_err !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", ovf_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [33:0] got, exp;
        kb_data = 8'h1C; kb_ready = 1'b1;
        @(posedge clk); #1;
        kb_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        n_total++;
        if ({kb_nextdata_n, wr_en, wr_addr, wr_data, cursor_row, cursor_col, last_ascii, key_count, ovf_err}
                !== {1'b1, 50'd0})
            $display("FAIL reset_mid got=%h exp=%h",
                {kb_nextdata_n, wr_en, wr_addr, wr_data, cursor_row, cursor_col, last_ascii, key_count, ovf_err},
                {1'b1, 50'd0});
        else n_pass++;
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
        n_total++;
        if ({kb_nextdata_n, wr_en} !== 2'b10)
            $display("FAIL reset_mid_idle got=%b exp=10", {kb_nextdata_n, wr_en});
        else n_pass++;
        drive(8'h1C, 0, got, exp);
        n_total++;
        if (got !== exp) $display("FAIL reset_mid_reread got=%h exp=%h", got, exp);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [33:0] got, exp;
        logic [7:0] c;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: c = 8'hF0;
                1: c = 8'hE0;
                2: c = $urandom_range(0, 1) ? 8'h12 : 8'h59;
                3: c = 8'h5A;
                4: c = 8'h66;
                9: c = 8'($urandom);
                default: c = rand_printable();
            endcase
            drive(c, 0, got, exp);
            n_total++;
            if (got !== exp) $display("FAIL random code=%02h got=%h exp=%h", c, got, exp);
            else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        n_total++;
        if ({last_ascii, key_count} !== {8'(m_last), 8'(m_count)})
            $display("FAIL random_counters got=%h exp=%h", {last_ascii, key_count}, {8'(m_last), 8'(m_count)});
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_shift();
        test_wrap();
        test_backspace();
        test_ext_enter();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
